// File: rtl/multicycle_control.sv
// multicycle_control: state sequencer for the multi-cycle MIPS datapath.
// Controls are decoded from State, qualified by Opcode and MemReady.
module multicycle_control #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDstn,
  output logic       RegWrite,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic       BusErr,
  output logic [3:0] State
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(WAIT_LIMIT - 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ANDIEX = 4'd9,
    S_IMMWB  = 4'd10,
    S_BRANCH = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_wait;
  logic          w_tout;
  logic          w_hold;
  logic          w_legal;

  assign w_wait = (r_state == S_FETCH) ||
                  (r_state == S_MEMRD) ||
                  (r_state == S_MEMWR);
  assign w_tout = (WAIT_LIMIT > 0) && w_wait &&
                  !MemReady && (r_cnt == LIM);
  assign w_hold = w_wait && !MemReady && !w_tout;

  always_comb begin
    case (Opcode)
      OP_R, OP_ADDI, OP_LW, OP_SW,
      OP_ANDI, OP_BEQ, OP_JAL: w_legal = 1'b1;
      default:                 w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      // Counter saturates so a disabled limit never wraps.
      if (!w_hold)
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;

      unique case (r_state)
        S_FETCH:
          if (MemReady) r_state <= S_DECODE;
        S_DECODE:
          case (Opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXEC;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_ANDI:      r_state <= S_ANDIEX;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_JAL:       r_state <= S_JAL;
            default:      r_state <= S_FETCH;
          endcase
        S_MEMADR:
          if (Opcode == OP_LW)
            r_state <= S_MEMRD;
          else if (Opcode == OP_SW)
            r_state <= S_MEMWR;
          else
            r_state <= S_FETCH;
        S_MEMRD:
          if (MemReady)
            r_state <= S_MEMWB;
          else if (w_tout)
            r_state <= S_FETCH;
        S_MEMWR:
          if (MemReady || w_tout) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_ADDIEX: r_state <= S_IMMWB;
        S_ANDIEX: r_state <= S_IMMWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 2'b00;
    RegDstn     = 2'b00;
    RegWrite    = 1'b0;
    ALUsrcA     = 1'b0;
    ALUsrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSource    = 2'b00;
    Illegal     = 1'b0;
    BusErr      = 1'b0;
    State       = 4'd0;
    // Gating by rst_n keeps the FETCH decode quiet during reset.
    if (rst_n) begin
      State  = r_state;
      BusErr = w_tout;
      unique case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUsrcB = 2'b01;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        S_DECODE: begin
          ALUsrcB = 2'b11;
          Illegal = !w_legal;
        end
        S_MEMADR: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'b10;
        end
        S_MEMRD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 2'b01;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXEC: begin
          ALUsrcA = 1'b1;
          ALUop   = 2'b10;
        end
        S_ALUWB: begin
          RegDstn  = 2'b01;
          RegWrite = 1'b1;
        end
        S_ADDIEX: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'b10;
        end
        S_ANDIEX: begin
          ALUsrcA = 1'b1;
          ALUsrcB = 2'b10;
          ALUop   = 2'b11;
        end
        S_IMMWB: RegWrite = 1'b1;
        S_BRANCH: begin
          ALUsrcA     = 1'b1;
          ALUop       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JAL: begin
          RegDstn  = 2'b10;
          MemtoReg = 2'b10;
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        default: State = r_state;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequencing controller for the multi-cycle variant of the MIPS datapath. One ALU, one shared instruction/data memory port, and an instruction register (IR) are reused across states.
- Walks each instruction through fetch/decode/execute/memory/writeback states and drives every datapath select and write-enable per cycle.
- Stalls on a memory ready handshake.
- Supports opcodes R (000000), addi (001000), lw (100011), sw (101011), andi (001100), beq (000100), jal (000011).

Parameters:
WAIT_LIMIT, 15, maximum consecutive cycles a memory-wait state holds without MemReady before aborting; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
Opcode  input  6  IR[31:26]; stable from DECODE until the next FETCH completes
MemReady  input  1  memory completes the current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load qualified by ALU zero (beq)
IorD  output  1  0 = memory address from PC, 1 = from ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load IR from memory data
MemtoReg  output  2  00 ALUOut, 01 MDR, 10 PC (link)
RegDstn  output  2  00 rt, 01 rd, 10 $31
RegWrite  output  1  register file write
ALUsrcA  output  1  0 PC, 1 rs
ALUsrcB  output  2  00 rt, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
ALUop  output  2  00 add, 01 sub (beq), 10 funct-decoded, 11 and
PCSource  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
Illegal  output  1  one-cycle pulse on an undefined opcode
BusErr  output  1  one-cycle pulse on a memory-wait timeout
State  output  4  current state code (debug)

Behaviour:
- Reset: while rst_n=0, State=FETCH(0), the wait counter is 0, and all outputs are 0, including the combinational ones. The first post-reset cycle is FETCH.
- Outputs are decoded from State, with Opcode and MemReady qualifiers noted below. Any signal not listed for a state is 0; no X is ever driven.
- FETCH(0): MemRead=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=00, PCSource=00. If MemReady=1: IRWrite=1, PCWrite=1, go to DECODE. Otherwise hold.
- DECODE(1): ALUsrcA=0, ALUsrcB=11, ALUop=00 (precompute branch target). Next state by Opcode:
  - lw/sw -> MEMADR
  - R -> EXEC
  - addi -> ADDIEX
  - andi -> ANDIEX
  - beq -> BRANCH
  - jal -> JAL
  - any other opcode -> FETCH, with Illegal=1 this cycle.
- MEMADR(2): ALUsrcA=1, ALUsrcB=10, ALUop=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD(3): IorD=1, MemRead=1. Hold until MemReady=1, then MEMWB.
- MEMWB(4): RegDstn=00, MemtoReg=01, RegWrite=1 -> FETCH.
- MEMWR(5): IorD=1, MemWrite=1. Hold until MemReady=1, then FETCH.
- EXEC(6): ALUsrcA=1, ALUsrcB=00, ALUop=10 -> ALUWB.
- ALUWB(7): RegDstn=01, MemtoReg=00, RegWrite=1 -> FETCH.
- ADDIEX(8): ALUsrcA=1, ALUsrcB=10, ALUop=00 -> IMMWB.
- ANDIEX(9): ALUsrcA=1, ALUsrcB=10, ALUop=11 -> IMMWB.
- IMMWB(10): RegDstn=00, MemtoReg=00, RegWrite=1 -> FETCH.
- BRANCH(11): ALUsrcA=1, ALUsrcB=00, ALUop=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JAL(12): RegDstn=10, MemtoReg=10, RegWrite=1, PCWrite=1, PCSource=10 -> FETCH. The PC already holds PC+4 from FETCH, so the link value is correct.
- Codes 13-15: unreachable. If entered, all outputs are 0 and the next state is FETCH.
- Latency with MemReady tied high (cycles from FETCH entry to the next FETCH entry):

| Instruction | Cycles |
|---|---|
| lw | 5 |
| R, sw, addi, andi | 4 |
| beq, jal | 3 |

  Each extra cycle of MemReady=0 in a wait state adds one cycle.
- Wait counter: counts consecutive cycles spent in FETCH/MEMRD/MEMWR with MemReady=0. It clears on any state change or when MemReady=1.
- Timeout: if the counter reaches WAIT_LIMIT (WAIT_LIMIT>0) while MemReady=0, then in that cycle BusErr=1 and the next state is FETCH.
  - FETCH timeout: retry at the same PC (no PCWrite/IRWrite).
  - MEMRD timeout: abort with no register write.
  - MEMWR timeout: abort the store; MemWrite drops the next cycle.
- MemReady=1 on the cycle the counter would expire: completion wins, BusErr=0.
- MemReady is ignored in non-wait states.
- Reset asserted mid-instruction: immediate return to FETCH with outputs 0. No partial writeback completes after rst_n falls.

Test Plan:
- Reset, MemReady=1, Opcode=000000 -> State 0,1,6,7,0. RegWrite=1 only in state 7, with RegDstn=01 and ALUop=10 in state 6.
- lw (100011), MemReady low for 3 cycles in MEMRD -> MEMRD held 4 cycles with MemRead=1, IorD=1. MEMWB is asserted once with MemtoReg=01; total 8 cycles.
- sw then beq (000100) -> sw: MemWrite=1 exactly once in state 5, RegWrite never set. beq: PCWriteCond=1, PCSource=01, ALUop=01 in state 11; 3 cycles.
- jal (000011) -> state 12: PCWrite=1, PCSource=10, RegDstn=10, MemtoReg=10, RegWrite=1. Opcode 111111 -> Illegal pulses in DECODE, next state 0, no writes.
- WAIT_LIMIT=15, MemReady held 0 in FETCH -> BusErr=1 on the 15th wait cycle, FETCH re-entered, PCWrite/IRWrite never asserted. A second run with MemReady=1 on cycle 15 -> no BusErr, DECODE entered.
- rst_n pulled low during ALUWB -> RegWrite drops immediately (asynchronous), State=0. After release, FETCH with MemRead=1.
